// File: rtl/four_to_one_mux.sv
// Four-way WIDTH-bit selector steered by {a,b}; build-time choice of a
// registered (one-cycle, synchronous reset) or purely combinational output.
module four_to_one_mux #(
  parameter int WIDTH      = 1,
  parameter bit REGISTERED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sel_d;

  // One select decode shared by every bit keeps the selection uniform across q.
  always_comb begin
    sel_d = A;
    unique case ({a, b})
      2'b00:   sel_d = A;
      2'b01:   sel_d = B;
      2'b10:   sel_d = C;
      2'b11:   sel_d = D;
      default: sel_d = 'x;
    endcase
  end

  generate
    if (REGISTERED) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= sel_d;
      end
    end else begin : g_comb
      // clk and rst are intentionally unused in the combinational build.
      logic unused_ok;
      assign unused_ok = ^{clk, rst};
      assign q = sel_d;
    end
  endgenerate

endmodule

// File: tb/tb_four_to_one_mux.sv
// Directed and randomized checks of both output-path builds of four_to_one_mux.
module tb_four_to_one_mux;

  int vectors = 0;
  int miscompares = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational build, WIDTH=1.
  logic ca, cb, cA, cB, cC, cD, cq;
  logic crst;
  // Registered build, WIDTH=8.
  logic rst, ra, rb;
  logic [7:0] rA, rB, rC, rD, rq;

  four_to_one_mux #(.WIDTH(1), .REGISTERED(0)) u_comb (
    .clk(clk), .rst(crst), .a(ca), .b(cb),
    .A(cA), .B(cB), .C(cC), .D(cD), .q(cq)
  );

  four_to_one_mux #(.WIDTH(8), .REGISTERED(1)) u_reg (
    .clk(clk), .rst(rst), .a(ra), .b(rb),
    .A(rA), .B(rB), .C(rC), .D(rD), .q(rq)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb_select;
    logic [3:0] onehot;
    for (int s = 0; s < 4; s++) begin
      onehot = 4'b0001 << s;
      {ca, cb} = 2'(s);
      {cD, cC, cB, cA} = onehot;
      #10;
      vectors++;
      if (cq !== 1'b1) begin
        miscompares++;
        $display("FAIL comb_select sel=%0d q=%b expected=1", s, cq);
      end
    end
  endtask

  task automatic test_comb_isolation;
    logic [3:0] onecold;
    for (int s = 0; s < 4; s++) begin
      onecold = ~(4'b0001 << s);
      {ca, cb} = 2'(s);
      {cD, cC, cB, cA} = onecold;
      #10;
      vectors++;
      if (cq !== 1'b0) begin
        miscompares++;
        $display("FAIL comb_isolation sel=%0d q=%b expected=0", s, cq);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; {ra, rb} = 2'b11;
    rA = 8'h11; rB = 8'h22; rC = 8'h33; rD = 8'h44;
    tick;
    vectors++;
    if (rq !== 8'h00) begin
      miscompares++;
      $display("FAIL reset q=%h expected=00", rq);
    end
  endtask

  task automatic test_select_step;
    logic [7:0] exp_tbl [4];
    logic [7:0] prev;
    exp_tbl[0] = 8'h11; exp_tbl[1] = 8'h22; exp_tbl[2] = 8'h33; exp_tbl[3] = 8'h44;
    rst = 1'b0;
    prev = 8'h00;
    for (int s = 0; s < 4; s++) begin
      {ra, rb} = 2'(s);
      #2;
      vectors++;
      if (rq !== prev) begin
        miscompares++;
        $display("FAIL step_hold sel=%0d q=%h expected=%h", s, rq, prev);
      end
      tick;
      vectors++;
      if (rq !== exp_tbl[s]) begin
        miscompares++;
        $display("FAIL step_load sel=%0d q=%h expected=%h", s, rq, exp_tbl[s]);
      end
      prev = exp_tbl[s];
    end
  endtask

  task automatic test_sync_reset;
    rst = 1'b1;
    #2;
    vectors++;
    if (rq !== 8'h44) begin
      miscompares++;
      $display("FAIL sync_reset_early q=%h expected=44", rq);
    end
    tick;
    vectors++;
    if (rq !== 8'h00) begin
      miscompares++;
      $display("FAIL sync_reset_edge q=%h expected=00", rq);
    end
    rst = 1'b0; {ra, rb} = 2'b10;
    tick;
    vectors++;
    if (rq !== 8'h33) begin
      miscompares++;
      $display("FAIL reset_release q=%h expected=33", rq);
    end
  endtask

  task automatic test_back_to_back;
    {ra, rb} = 2'b00;
    tick;
    vectors++;
    if (rq !== 8'h11) begin
      miscompares++;
      $display("FAIL simul_pre q=%h expected=11", rq);
    end
    {ra, rb} = 2'b11; rD = 8'h5A;
    tick;
    vectors++;
    if (rq !== 8'h5A) begin
      miscompares++;
      $display("FAIL simul_change q=%h expected=5a", rq);
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_q;
    logic [1:0] s;
    logic [3:0] cdat;
    for (int i = 0; i < 1000; i++) begin
      s = 2'($urandom_range(0, 3));
      {ra, rb} = s;
      rA = 8'($urandom); rB = 8'($urandom); rC = 8'($urandom); rD = 8'($urandom);
      rst = ($urandom_range(0, 15) == 0);
      if (rst)          exp_q = 8'h00;
      else if (s == 0)  exp_q = rA;
      else if (s == 1)  exp_q = rB;
      else if (s == 2)  exp_q = rC;
      else              exp_q = rD;
      cdat = 4'($urandom);
      {cD, cC, cB, cA} = cdat;
      {ca, cb} = 2'($urandom_range(0, 3));
      crst = 1'($urandom);
      tick;
      vectors++;
      if (rq !== exp_q) begin
        miscompares++;
        $display("FAIL random_reg cycle=%0d q=%h expected=%h", i, rq, exp_q);
      end
      vectors++;
      if (cq !== cdat[{ca, cb}]) begin
        miscompares++;
        $display("FAIL random_comb cycle=%0d q=%b expected=%b", i, cq, cdat[{ca, cb}]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    crst = 1'b0; ca = 1'b0; cb = 1'b0;
    cA = 1'b0; cB = 1'b0; cC = 1'b0; cD = 1'b0;
    rst = 1'b1; ra = 1'b0; rb = 1'b0;
    rA = '0; rB = '0; rC = '0; rD = '0;
    #1;
    test_comb_select;
    test_comb_isolation;
    test_reset;
    test_select_step;
    test_sync_reset;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
